// File: rtl/eth_pkg.sv
// Shared Ethernet types: byte / packet-address typedefs, the TX arbiter state
// encoding and the TX arbiter watchdog defaults.
package eth_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PKT_ADDR_W = 11;

  typedef logic [BYTE_W-1:0]     TypeByte;
  typedef logic [PKT_ADDR_W-1:0] TypePktAddr;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_START     = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RELEASE   = 3'd4
  } TypeArbState;

  // Cycles allowed from eng_start until eng_busy rises.
  localparam int unsigned START_WAIT_DEFAULT = 16;
  // Cycles eng_busy may stay high before the frame is aborted.
  localparam int unsigned TIMEOUT_DEFAULT    = 20000;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   - request vector
//   last  - index of the most recently served source
//   pick  - one-hot winner: first set req bit searching upward from last+1,
//           wrapping modulo NUM_REQ
//   valid - some request is set
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  // Scan offsets 1..NUM_REQ so that `last` itself is considered last.
  always_comb begin
    logic [IDX_W-1:0] pos;
    pick  = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!valid && req[pos]) begin
        pick[pos] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin arbiter / sequencer in front of the single GMII
// transmit engine. Grants one frame source at a time, starts the engine with
// that source's length, muxes engine byte reads to the granted buffer and
// supervises completion with a start/busy watchdog.
//
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   req/req_len     - per-source level request and frame byte count
//   rd_data         - per-source buffer read data (combinational from rd_addr)
//   grant/ack/err   - one-hot owner, end-of-frame pulse, failure pulse
//   rd_addr         - engine read address forwarded to all sources
//   eng_start/eng_len/eng_abort - engine control (registered)
//   eng_rd_addr/eng_rd_data     - engine byte read port
//   eng_busy        - engine activity, preamble through inter-frame gap
//   busy            - arbiter not idle
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned START_WAIT = START_WAIT_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*BYTE_W-1:0] rd_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [LEN_W-1:0]          rd_addr,
  output logic                      eng_start,
  output logic [LEN_W-1:0]          eng_len,
  input  logic [LEN_W-1:0]          eng_rd_addr,
  output logic [BYTE_W-1:0]         eng_rd_data,
  input  logic                      eng_busy,
  output logic                      eng_abort,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [WD_W-1:0]  WD_MAX     = '1;
  // Limits are one below the cycle budget: the abort decision is registered.
  localparam logic [WD_W-1:0]  START_LIM  = WD_W'(START_WAIT - 1);
  localparam logic [WD_W-1:0]  DONE_LIM   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  TypeArbState state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wd_q, wd_d, wd_inc;

  logic [NUM_REQ-1:0] grant_d, ack_d, err_d;
  logic               eng_start_d, eng_abort_d, busy_d;
  logic [LEN_W-1:0]   eng_len_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [LEN_W-1:0]   pick_len;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Winner index and its frame length.
  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = IDX_W'(i);
        pick_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Engine read path: address straight through, data from the granted buffer.
  assign rd_addr = eng_rd_addr;

  always_comb begin
    eng_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        eng_rd_data = eng_rd_data | rd_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Saturating watchdog increment.
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wd_d        = wd_q;
    grant_d     = grant;
    ack_d       = '0;
    err_d       = '0;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    eng_len_d   = eng_len;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          last_d    = pick_idx;
          eng_len_d = pick_len;
          if (pick_len == '0) begin
            // Empty frame: fail it immediately without touching the engine.
            ack_d   = pick;
            err_d   = pick;
            grant_d = '0;
          end else begin
            grant_d = pick;
            state_d = ARB_START;
          end
        end
      end

      ARB_START: begin
        eng_start_d = 1'b1;
        wd_d        = '0;
        state_d     = ARB_WAIT_BUSY;
      end

      ARB_WAIT_BUSY: begin
        if (eng_busy) begin
          wd_d    = '0;
          state_d = ARB_WAIT_DONE;
        end else if (wd_q >= START_LIM) begin
          eng_abort_d = 1'b1;
          ack_d       = grant;
          err_d       = grant;
          state_d     = ARB_RELEASE;
        end else begin
          wd_d = wd_inc;
        end
      end

      ARB_WAIT_DONE: begin
        // A falling eng_busy wins over a coincident timeout.
        if (!eng_busy) begin
          ack_d   = grant;
          state_d = ARB_RELEASE;
        end else if (wd_q >= DONE_LIM) begin
          eng_abort_d = 1'b1;
          ack_d       = grant;
          err_d       = grant;
          state_d     = ARB_RELEASE;
        end else begin
          wd_d = wd_inc;
        end
      end

      ARB_RELEASE: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= LAST_RESET;
      wd_q      <= '0;
      grant     <= '0;
      ack       <= '0;
      err       <= '0;
      eng_start <= 1'b0;
      eng_len   <= '0;
      eng_abort <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      grant     <= grant_d;
      ack       <= ack_d;
      err       <= err_d;
      eng_start <= eng_start_d;
      eng_len   <= eng_len_d;
      eng_abort <= eng_abort_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus randomized
// request/engine behaviour, checked against a transaction-level model
// (round-robin pointer + expected event cycles derived from the latencies).
module tb_eth_tx_arbiter;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned START_WAIT = 16;
  localparam int unsigned TIMEOUT    = 20000;

  logic                     clock;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     rd_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       err;
  logic [LEN_W-1:0]         rd_addr;
  logic                     eng_start;
  logic [LEN_W-1:0]         eng_len;
  logic [LEN_W-1:0]         eng_rd_addr;
  logic [7:0]               eng_rd_data;
  logic                     eng_busy;
  logic                     eng_abort;
  logic                     busy;

  int n_checks = 0;
  int n_errors = 0;
  int last_m;

  eth_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LEN_W      (LEN_W),
    .START_WAIT (START_WAIT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_len     (req_len),
    .rd_data     (rd_data),
    .grant       (grant),
    .ack         (ack),
    .err         (err),
    .rd_addr     (rd_addr),
    .eng_start   (eng_start),
    .eng_len     (eng_len),
    .eng_rd_addr (eng_rd_addr),
    .eng_rd_data (eng_rd_data),
    .eng_busy    (eng_busy),
    .eng_abort   (eng_abort),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Source buffer contents: a distinct byte pattern per source.
  function automatic logic [7:0] buf_byte(input int src, input logic [LEN_W-1:0] a);
    return 8'(32'(a) * (2 * src + 3) + 17 * src + 1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) rd_data[i*8 +: 8] = buf_byte(i, rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  // Reference arbitration: first requester after `last`, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [LEN_W-1:0] get_len(input int i);
    return req_len[i*LEN_W +: LEN_W];
  endfunction

  task automatic set_len(input int i, input int len);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_start"}, 32'(eng_start), 0);
    chk({tag, "_len"}, 32'(eng_len), 0);
    chk({tag, "_abort"}, 32'(eng_abort), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdata"}, 32'(eng_rd_data), 0);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 32'(eng_rd_addr));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = '0;
    eng_busy = 1'b0;
    last_m   = NUM_REQ - 1;
    tick();
    tick();
    chk_all_zero("rst");
    reset_n = 1'b1;
  endtask

  // One cycle with nothing requested: arbiter must stay quiet.
  task automatic idle_cycle();
    eng_rd_addr = LEN_W'($urandom);
    #1;
    chk("idle_rdata", 32'(eng_rd_data), 0);
    tick();
    chk("idle_grant", 32'(grant), 0);
    chk("idle_ack", 32'(ack), 0);
    chk("idle_start", 32'(eng_start), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  // Serve one frame starting from an idle arbiter. d: cycles after eng_start
  // before the engine raises busy (<0: never); dur: cycles busy stays high.
  // Returns at the first idle cycle afterwards.
  task automatic serve_one(input int d, input int dur, input bit sweep,
                           output logic [NUM_REQ-1:0] seen_grant);
    int idx, ack_at, c;
    bit fail;
    logic [LEN_W-1:0] l;
    seen_grant = '0;
    if (req == '0) begin
      idle_cycle();
      return;
    end
    idx    = model_pick(req, last_m);
    last_m = idx;
    l      = get_len(idx);
    eng_busy    = 1'b0;
    eng_rd_addr = LEN_W'($urandom);
    #1;
    chk("pre_rdata", 32'(eng_rd_data), 0);
    tick();
    seen_grant = grant;
    if (l == '0) begin
      chk("zl_ack", 32'(ack), 32'(oh(idx)));
      chk("zl_err", 32'(err), 32'(oh(idx)));
      chk("zl_grant", 32'(grant), 0);
      chk("zl_start", 32'(eng_start), 0);
      chk("zl_busy", 32'(busy), 0);
      req[idx] = 1'b0;
      return;
    end
    chk("grant", 32'(grant), 32'(oh(idx)));
    chk("grant_busy", 32'(busy), 1);
    chk("grant_ack", 32'(ack), 0);
    chk("grant_start", 32'(eng_start), 0);
    tick();
    chk("start", 32'(eng_start), 1);
    chk("start_len", 32'(eng_len), 32'(l));
    if (d < 0) begin
      ack_at = START_WAIT;
      fail   = 1'b1;
    end else if (dur <= TIMEOUT) begin
      ack_at = d + dur + 1;
      fail   = 1'b0;
    end else begin
      ack_at = d + 1 + TIMEOUT;
      fail   = 1'b1;
    end
    c = 0;
    while (c < ack_at) begin
      eng_busy    = (d >= 0) && (c >= d) && (c < d + dur);
      eng_rd_addr = sweep ? LEN_W'(c % 64) : LEN_W'($urandom);
      #1;
      chk("rdata", 32'(eng_rd_data), 32'(buf_byte(idx, eng_rd_addr)));
      chk("rdaddr", 32'(rd_addr), 32'(eng_rd_addr));
      tick();
      c++;
      if (c < ack_at) begin
        chk("run_ack", 32'(ack), 0);
        chk("run_abort", 32'(eng_abort), 0);
        chk("run_start", 32'(eng_start), 0);
        chk("run_grant", 32'(grant), 32'(oh(idx)));
        chk("run_busy", 32'(busy), 1);
      end
    end
    chk("end_ack", 32'(ack), 32'(oh(idx)));
    chk("end_err", 32'(err), fail ? 32'(oh(idx)) : 0);
    chk("end_abort", 32'(eng_abort), 32'(fail));
    chk("end_grant", 32'(grant), 32'(oh(idx)));
    req[idx] = 1'b0;
    eng_busy = 1'b0;
    tick();
    chk("rel_grant", 32'(grant), 0);
    chk("rel_ack", 32'(ack), 0);
    chk("rel_abort", 32'(eng_abort), 0);
    chk("rel_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] g;
    req         = '0;
    req_len     = '0;
    eng_busy    = 1'b0;
    eng_rd_addr = '0;
    reset_n     = 1'b0;
    do_reset();

    // Single frame straight out of reset.
    req = 3'b001;
    set_len(0, 60);
    serve_one(0, 100, 1'b0, g);
    chk("t1_grant", 32'(g), 32'b001);

    // Continuous requests from all sources: strict rotation.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 64);
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      serve_one(int'($urandom_range(0, START_WAIT - 1)), int'($urandom_range(1, 20)), 1'b0, g);
      chk("rr_order", 32'(g), 32'(oh(n % NUM_REQ)));
      req = 3'b111;
    end
    req = '0;
    set_len(0, 0);
    set_len(1, 0);
    set_len(2, 0);
    idle_cycle();

    // Zero-length frame.
    req = 3'b010;
    serve_one(0, 5, 1'b0, g);
    chk("zl_nogrant", 32'(g), 0);
    idle_cycle();

    // Engine never answers; then latest possible busy is still accepted.
    req = 3'b100;
    set_len(2, 100);
    serve_one(-1, 0, 1'b0, g);
    req = 3'b001;
    set_len(0, 77);
    serve_one(START_WAIT - 1, 3, 1'b0, g);

    // Stuck busy times out; a fall exactly at the limit still succeeds.
    req = 3'b011;
    set_len(0, 300);
    set_len(1, 301);
    serve_one(2, TIMEOUT + 40, 1'b0, g);
    chk("stuck_grant", 32'(g), 32'b010);
    serve_one(1, TIMEOUT, 1'b0, g);
    chk("after_stuck", 32'(g), 32'b001);

    // Read-address sweep with source 2 granted.
    req = 3'b100;
    set_len(2, 64);
    serve_one(0, 80, 1'b1, g);

    // Randomized requests, lengths and engine behaviour.
    for (int it = 0; it < 40; it++) begin
      int d, dur;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          set_len(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047)));
        end
      end
      d   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, START_WAIT - 1));
      dur = int'($urandom_range(1, 30));
      serve_one(d, dur, 1'b0, g);
    end
    req = '0;
    idle_cycle();

    // Reset asserted mid-frame clears registered outputs immediately.
    req = 3'b001;
    set_len(0, 100);
    tick();
    tick();
    eng_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_grant_pre", 32'(grant), 32'b001);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    eng_busy = 1'b0;
    req      = '0;
    last_m   = NUM_REQ - 1;
    tick();
    reset_n = 1'b1;
    req = 3'b011;
    set_len(0, 10);
    set_len(1, 10);
    serve_one(0, 4, 1'b0, g);
    chk("post_rst_grant", 32'(g), 32'b001);
    req = '0;
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
